i2c_bus_arbiter: RTL and testbench

- Shares one i2c_controller between NUM_REQ requesters, e.g. codec config, DAC setup and a debug button path.
- Round-robin arbitration; latches the winner's address, mode and byte; sequences the controller's enable/ready handshake.
- Returns a done pulse plus read data to the winner.
- Sits between the requesters and i2c_controller, clocked on the same clock as the controller.

---
 rtl/i2c_bus_arbiter_if.sv | 35 +++
 rtl/i2c_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_bus_arbiter_if.sv
// i2c_bus_arbiter_if
// Link between the bus arbiter and the shared i2c_controller.
//   ctrl_enable   : start strobe to the controller (one cycle)
//   ctrl_mode     : 1 = write, 0 = read
//   ctrl_addr     : 7-bit peripheral address
//   ctrl_byte     : byte to transmit
//   ctrl_ready    : controller idle/ready
//   ctrl_byte_reg : byte received by the controller
// The master modport is the arbiter side; the slave modport is the controller side.
interface i2c_bus_arbiter_if;
    logic       ctrl_enable;
    logic       ctrl_mode;
    logic [6:0] ctrl_addr;
    logic [7:0] ctrl_byte;
    logic       ctrl_ready;
    logic [7:0] ctrl_byte_reg;

    modport master (
        output ctrl_enable,
        output ctrl_mode,
        output ctrl_addr,
        output ctrl_byte,
        input  ctrl_ready,
        input  ctrl_byte_reg
    );

    modport slave (
        input  ctrl_enable,
        input  ctrl_mode,
        input  ctrl_addr,
        input  ctrl_byte,
        output ctrl_ready,
        output ctrl_byte_reg
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter
// Shares one i2c_controller between NUM_REQ requesters using round-robin
// arbitration. The winner's mode/address/byte are latched and held on the
// controller link for the whole transaction, the controller's enable/ready
// handshake is sequenced, and a done pulse plus the received byte are
// returned to the winner. Each handshake phase is bounded by TIMEOUT_CYCLES.
// Ports:
//   clk, reset       : shared clock, synchronous active-high reset
//   req              : level request per requester, held until done
//   req_mode         : per-requester mode bit (1 = write)
//   req_addr         : per-requester address, requester i at [7i+6:7i]
//   req_data         : per-requester byte, requester i at [8i+7:8i]
//   grant            : one-hot, high from START through RELEASE
//   done             : one-cycle pulse to the winner at transaction end
//   rd_data          : controller byte captured at completion
//   timeout_err      : pulses with done when the transaction was aborted
//   busy             : high whenever not IDLE
//   ctrl             : controller link (i2c_bus_arbiter_if.master)
module i2c_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_mode,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [7:0]             rd_data,
    output logic                   timeout_err,
    output logic                   busy,
    i2c_bus_arbiter_if.master      ctrl
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] WAIT_BUSY = 3'd2;
    localparam logic [2:0] WAIT_DONE = 3'd3;
    localparam logic [2:0] RELEASE   = 3'd4;

    logic [2:0]       state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic [CNT_W-1:0] cnt;
    logic             aborted;

    logic             sel_found;
    logic [PTR_W-1:0] sel_idx;
    logic             sel_mode;
    logic [6:0]       sel_addr;
    logic [7:0]       sel_data;
    int               cand;

    // Round-robin pick: walk from the requester nearest above the pointer
    // downward in distance so the closest set bit (wrapping) overwrites last.
    always_comb begin
        sel_found = |req;
        sel_idx   = '0;
        sel_mode  = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        cand      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (req[cand]) begin
                sel_idx  = PTR_W'(cand);
                sel_mode = req_mode[cand];
                sel_addr = req_addr[7*cand +: 7];
                sel_data = req_data[8*cand +: 8];
            end
        end
    end

    // Pulses and status are decoded from the registered state so they are
    // glitch-free per cycle and automatically return to zero under reset.
    assign busy             = (state != IDLE);
    assign ctrl.ctrl_enable = (state == START);
    assign done             = (state == RELEASE) ? grant : '0;
    assign timeout_err      = (state == RELEASE) && aborted;

    // Transaction sequencer. The timeout counter restarts on entry to each
    // wait phase; an abort skips the rd_data capture so the previous byte
    // remains visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= '0;
            win            <= '0;
            cnt            <= '0;
            aborted        <= 1'b0;
            grant          <= '0;
            rd_data        <= '0;
            ctrl.ctrl_mode <= 1'b0;
            ctrl.ctrl_addr <= '0;
            ctrl.ctrl_byte <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found && ctrl.ctrl_ready) begin
                        win            <= sel_idx;
                        grant          <= ONE_HOT0 << sel_idx;
                        ctrl.ctrl_mode <= sel_mode;
                        ctrl.ctrl_addr <= sel_addr;
                        ctrl.ctrl_byte <= sel_data;
                        aborted        <= 1'b0;
                        state          <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!ctrl.ctrl_ready) begin
                        cnt   <= '0;
                        state <= WAIT_DONE;
                    end else if (cnt == CNT_LAST) begin
                        aborted <= 1'b1;
                        state   <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (ctrl.ctrl_ready) begin
                        rd_data <= ctrl.ctrl_byte_reg;
                        state   <= RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        aborted <= 1'b1;
                        state   <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    grant <= '0;
                    ptr   <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    state <= IDLE;
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter
// Directed bench for i2c_bus_arbiter with a small behavioural controller
// model. A second instance with TIMEOUT_CYCLES=16 shares all inputs and is
// only examined in the timeout scenario.
module tb_i2c_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req, req_mode;
    logic [27:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  grant, done, grant_to, done_to;
    logic [7:0]  rd_data, rd_data_to;
    logic        timeout_err, busy, timeout_err_to, busy_to;

    logic        ready_drv;
    logic [7:0]  byte_drv;

    int checks = 0;
    int errors = 0;

    i2c_bus_arbiter_if ctrl_if ();
    i2c_bus_arbiter_if ctrl_if_to ();

    assign ctrl_if.ctrl_ready       = ready_drv;
    assign ctrl_if.ctrl_byte_reg    = byte_drv;
    assign ctrl_if_to.ctrl_ready    = ready_drv;
    assign ctrl_if_to.ctrl_byte_reg = byte_drv;

    i2c_bus_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(4096)) dut (
        .clk(clk), .reset(reset), .req(req), .req_mode(req_mode),
        .req_addr(req_addr), .req_data(req_data), .grant(grant), .done(done),
        .rd_data(rd_data), .timeout_err(timeout_err), .busy(busy), .ctrl(ctrl_if)
    );

    i2c_bus_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut_to (
        .clk(clk), .reset(reset), .req(req), .req_mode(req_mode),
        .req_addr(req_addr), .req_data(req_data), .grant(grant_to), .done(done_to),
        .rd_data(rd_data_to), .timeout_err(timeout_err_to), .busy(busy_to), .ctrl(ctrl_if_to)
    );

    always #5 clk = ~clk;

    // Controller model: one edge after sampling enable it drops ready, then
    // raises it (with model_byte) model_n edges later.
    int         model_n = 3;
    bit         model_never = 1'b0;
    logic [7:0] model_byte = 8'h3C;
    int         phase = 0;
    int         mcnt = 0;
    logic       en_neg = 1'b0;
    int         enable_count = 0;

    always @(negedge clk) begin
        en_neg = ctrl_if.ctrl_enable;
        if (ctrl_if.ctrl_enable === 1'b1) enable_count++;
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            phase     = 0;
            ready_drv = 1'b1;
        end else begin
            case (phase)
                0: if (en_neg && !model_never) phase = 1;
                1: begin ready_drv = 1'b0; mcnt = model_n; phase = 2; end
                default: begin
                    mcnt--;
                    if (mcnt == 0) begin
                        ready_drv = 1'b1;
                        byte_drv  = model_byte;
                        phase     = 0;
                    end
                end
            endcase
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (grant != 4'b0) break;
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done != 4'b0) break;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (grant !== 4'b0) begin errors++; $display("[TB] FAIL reset_grant got %b want 0000", grant); end
        checks++; if (done !== 4'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0000", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err got %b want 0", timeout_err); end
        checks++; if (ctrl_if.ctrl_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_enable got %b want 0", ctrl_if.ctrl_enable); end
        checks++; if (ctrl_if.ctrl_mode !== 1'b0) begin errors++; $display("[TB] FAIL reset_mode got %b want 0", ctrl_if.ctrl_mode); end
        checks++; if (ctrl_if.ctrl_addr !== 7'd0) begin errors++; $display("[TB] FAIL reset_addr got %0d want 0", ctrl_if.ctrl_addr); end
        checks++; if (ctrl_if.ctrl_byte !== 8'd0) begin errors++; $display("[TB] FAIL reset_byte got %0d want 0", ctrl_if.ctrl_byte); end
        checks++; if (rd_data !== 8'd0) begin errors++; $display("[TB] FAIL reset_rd_data got %h want 00", rd_data); end
        checks++; if (busy_to !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_to got %b want 0", busy_to); end
    endtask

    task automatic test_single_write();
        int cyc, lat, hold_bad;
        model_n = 20;
        model_byte = 8'h3C;
        req_mode = 4'b0100;
        req_addr = '0; req_addr[20:14] = 7'd4;
        req_data = '0; req_data[23:16] = 8'd230;
        enable_count = 0;
        req = 4'b0100;
        wait_grant(cyc);
        checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL write_grant got %b want 0100", grant); end
        checks++; if (ctrl_if.ctrl_addr !== 7'd4) begin errors++; $display("[TB] FAIL write_addr got %0d want 4", ctrl_if.ctrl_addr); end
        checks++; if (ctrl_if.ctrl_byte !== 8'd230) begin errors++; $display("[TB] FAIL write_byte got %0d want 230", ctrl_if.ctrl_byte); end
        checks++; if (ctrl_if.ctrl_mode !== 1'b1) begin errors++; $display("[TB] FAIL write_mode got %b want 1", ctrl_if.ctrl_mode); end
        req_addr[20:14] = 7'd9;
        req_data[23:16] = 8'd1;
        lat = 0;
        hold_bad = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (grant !== 4'b0100) hold_bad++;
            if (done != 4'b0) break;
        end
        checks++; if (lat !== 23) begin errors++; $display("[TB] FAIL write_latency got %0d want 23", lat); end
        checks++; if (hold_bad !== 0) begin errors++; $display("[TB] FAIL write_grant_hold got %0d bad cycles want 0", hold_bad); end
        checks++; if (done !== 4'b0100) begin errors++; $display("[TB] FAIL write_done got %b want 0100", done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL write_timeout_err got %b want 0", timeout_err); end
        checks++; if (ctrl_if.ctrl_addr !== 7'd4) begin errors++; $display("[TB] FAIL write_addr_stable got %0d want 4", ctrl_if.ctrl_addr); end
        req = 4'b0;
        @(negedge clk);
        checks++; if (grant !== 4'b0) begin errors++; $display("[TB] FAIL write_grant_clear got %b want 0000", grant); end
        checks++; if (done !== 4'b0) begin errors++; $display("[TB] FAIL write_done_pulse got %b want 0000", done); end
        checks++; if (enable_count !== 1) begin errors++; $display("[TB] FAIL write_enable_count got %0d want 1", enable_count); end
    endtask

    task automatic test_pointer_wrap();
        int cyc;
        model_n = 3;
        req = 4'b1001;
        wait_grant(cyc);
        checks++; if (grant !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_first_grant got %b want 1000", grant); end
        wait_done(cyc);
        checks++; if (done !== 4'b1000) begin errors++; $display("[TB] FAIL wrap_first_done got %b want 1000", done); end
        req = 4'b0001;
        wait_grant(cyc);
        checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_second_grant got %b want 0001", grant); end
        wait_done(cyc);
        checks++; if (done !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_second_done got %b want 0001", done); end
        req = 4'b0;
    endtask

    task automatic test_contention();
        int cyc;
        logic [3:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;
        do_reset();
        model_n = 3;
        req = 4'b1111;
        wait_grant(cyc);
        checks++; if (grant !== order[0]) begin errors++; $display("[TB] FAIL contention_grant0 got %b want %b", grant, order[0]); end
        for (int i = 0; i < 5; i++) begin
            wait_done(cyc);
            checks++; if (done !== order[i]) begin errors++; $display("[TB] FAIL contention_done%0d got %b want %b", i, done, order[i]); end
            if (i < 4) begin
                @(negedge clk);
                checks++; if (grant !== 4'b0) begin errors++; $display("[TB] FAIL contention_gap%0d got %b want 0000", i, grant); end
                @(negedge clk);
                checks++; if (grant !== order[i+1]) begin errors++; $display("[TB] FAIL contention_grant%0d got %b want %b", i + 1, grant, order[i+1]); end
            end
        end
        req = 4'b0;
    endtask

    task automatic test_read_capture();
        int cyc;
        model_n = 5;
        model_byte = 8'hA5;
        req_mode = 4'b0000;
        req_addr[13:7] = 7'h50;
        req_data[15:8] = 8'h00;
        req = 4'b0010;
        wait_grant(cyc);
        checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL read_grant got %b want 0010", grant); end
        checks++; if (ctrl_if.ctrl_mode !== 1'b0) begin errors++; $display("[TB] FAIL read_mode got %b want 0", ctrl_if.ctrl_mode); end
        checks++; if (ctrl_if.ctrl_addr !== 7'h50) begin errors++; $display("[TB] FAIL read_addr got %h want 50", ctrl_if.ctrl_addr); end
        wait_done(cyc);
        checks++; if (done !== 4'b0010) begin errors++; $display("[TB] FAIL read_done got %b want 0010", done); end
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("[TB] FAIL read_rd_data got %h want a5", rd_data); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL read_timeout_err got %b want 0", timeout_err); end
        req = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cyc, lat;
        do_reset();
        model_never = 1'b1;
        byte_drv = 8'h77;
        req = 4'b0001;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (grant_to != 4'b0) break;
        end
        checks++; if (grant_to !== 4'b0001) begin errors++; $display("[TB] FAIL timeout_grant got %b want 0001", grant_to); end
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (done_to != 4'b0) break;
        end
        checks++; if (lat !== 17) begin errors++; $display("[TB] FAIL timeout_latency got %0d want 17", lat); end
        checks++; if (done_to !== 4'b0001) begin errors++; $display("[TB] FAIL timeout_done got %b want 0001", done_to); end
        checks++; if (timeout_err_to !== 1'b1) begin errors++; $display("[TB] FAIL timeout_err got %b want 1", timeout_err_to); end
        checks++; if (rd_data_to !== 8'h00) begin errors++; $display("[TB] FAIL timeout_rd_data got %h want 00", rd_data_to); end
        req = 4'b0011;
        @(negedge clk);
        checks++; if (timeout_err_to !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err_pulse got %b want 0", timeout_err_to); end
        @(negedge clk);
        checks++; if (grant_to !== 4'b0010) begin errors++; $display("[TB] FAIL timeout_ptr_advance got %b want 0010", grant_to); end
        model_never = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid_op();
        int cyc;
        model_n = 3;
        req = 4'b0001;
        wait_grant(cyc);
        wait_done(cyc);
        checks++; if (done !== 4'b0001) begin errors++; $display("[TB] FAIL midop_pre_done got %b want 0001", done); end
        req = 4'b0;
        model_n = 20;
        req_addr[13:7] = 7'h21;
        req = 4'b0010;
        wait_grant(cyc);
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midop_busy_before got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (grant !== 4'b0) begin errors++; $display("[TB] FAIL midop_grant got %b want 0000", grant); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midop_busy got %b want 0", busy); end
        checks++; if (ctrl_if.ctrl_enable !== 1'b0) begin errors++; $display("[TB] FAIL midop_enable got %b want 0", ctrl_if.ctrl_enable); end
        checks++; if (ctrl_if.ctrl_addr !== 7'd0) begin errors++; $display("[TB] FAIL midop_addr got %0d want 0", ctrl_if.ctrl_addr); end
        reset = 1'b0;
        req = 4'b0011;
        @(negedge clk);
        checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL midop_ptr_zero got %b want 0001", grant); end
        wait_done(cyc);
        req = 4'b0010;
        wait_grant(cyc);
        checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL midop_regrant got %b want 0010", grant); end
        wait_done(cyc);
        checks++; if (done !== 4'b0010) begin errors++; $display("[TB] FAIL midop_done got %b want 0010", done); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL midop_timeout_err got %b want 0", timeout_err); end
        req = 4'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_mode  = '0;
        req_addr  = '0;
        req_data  = '0;
        ready_drv = 1'b1;
        byte_drv  = 8'h00;
        $display("[TB] starting i2c_bus_arbiter bench");
        test_reset();
        test_single_write();
        test_pointer_wrap();
        test_contention();
        test_read_capture();
        test_timeout();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
